// File: rtl/vend_pkg.sv
// Shared types and helpers for the credit-accumulating vending controller.
package vend_pkg;

    typedef enum logic {VEND, REFUND} state_t;

    typedef enum logic [1:0] {COIN_NONE, COIN_1, COIN_2, COIN_3} coin_t;

    function automatic int coin_value(input logic [1:0] code,
                                      input int v1, input int v2, input int v3);
        case (coin_t'(code))
            COIN_1:  return v1;
            COIN_2:  return v2;
            COIN_3:  return v3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock_ctr.sv
// Item stock counter: reload to full, decrement per dispensed item, sold-out flag.
module vend_stock_ctr #(
    parameter int STOCK_DEPTH = 3,
    parameter int STOCK_W     = $clog2(STOCK_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dec,
    input  logic               reload,
    output logic [STOCK_W-1:0] stock,
    output logic               sold_out
);

    logic [STOCK_W-1:0] stock_nxt;

    always_comb begin
        stock_nxt = stock;
        if (reload)
            stock_nxt = STOCK_W'(STOCK_DEPTH);
        else if (dec && stock != '0)
            stock_nxt = stock - STOCK_W'(1);
    end

    // sold_out tracks the value being loaded so it always matches the stock register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stock    <= STOCK_W'(STOCK_DEPTH);
            sold_out <= 1'b0;
        end else begin
            stock    <= stock_nxt;
            sold_out <= (stock_nxt == '0);
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending controller: saturating credit, one drop per cycle, unit-pulse refund.
//   state  | meaning
//   VEND   | accept coins, dispense while credit covers PRICE
//   REFUND | pay back credit one unit per cycle, reject coins
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE       = 4,
    parameter int COIN1_VAL   = 1,
    parameter int COIN2_VAL   = 3,
    parameter int COIN3_VAL   = 5,
    parameter int CREDIT_W    = 4,
    parameter int STOCK_DEPTH = 3,
    parameter int STOCK_W     = $clog2(STOCK_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                refund,
    input  logic                restock,
    output logic                drop,
    output logic                change,
    output logic                coin_reject,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock
);

    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W:0] CMAX    = {1'b0, {CREDIT_W{1'b1}}};

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                drop_nxt, change_nxt, reject_nxt, do_reload;
    logic [CREDIT_W:0]   cv, cand, cand_less;
    logic                coin_nz;

    assign coin_nz   = (coin != 2'b00);
    assign cv        = (CREDIT_W + 1)'(coin_value(coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
    assign cand      = {1'b0, credit} + cv;
    assign cand_less = cand - PRICE_X;

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        drop_nxt   = 1'b0;
        change_nxt = 1'b0;
        reject_nxt = 1'b0;
        do_reload  = restock;
        case (state)
            VEND: begin
                if (refund && (credit != '0 || coin_nz)) begin
                    state_nxt  = REFUND;
                    reject_nxt = coin_nz;
                    do_reload  = 1'b0;
                end else if (restock) begin
                    if (cand > CMAX) reject_nxt = 1'b1;
                    else             credit_nxt = cand[CREDIT_W-1:0];
                end else if (cand >= PRICE_X && stock != '0) begin
                    if (cand_less > CMAX) begin
                        // coin would overflow: drop only on credit already held
                        reject_nxt = 1'b1;
                        if ({1'b0, credit} >= PRICE_X) begin
                            drop_nxt   = 1'b1;
                            credit_nxt = credit - PRICE_X[CREDIT_W-1:0];
                        end
                    end else begin
                        drop_nxt   = 1'b1;
                        credit_nxt = cand_less[CREDIT_W-1:0];
                    end
                end else if (cand > CMAX) begin
                    reject_nxt = 1'b1;
                end else begin
                    credit_nxt = cand[CREDIT_W-1:0];
                end
            end
            REFUND: begin
                reject_nxt = coin_nz;
                if (credit != '0) begin
                    credit_nxt = credit - CREDIT_W'(1);
                    change_nxt = 1'b1;
                end
                if (credit <= CREDIT_W'(1)) state_nxt = VEND;
            end
            default: state_nxt = VEND;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= VEND;
            credit      <= '0;
            drop        <= 1'b0;
            change      <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            drop        <= drop_nxt;
            change      <= change_nxt;
            coin_reject <= reject_nxt;
        end
    end

    vend_stock_ctr #(
        .STOCK_DEPTH (STOCK_DEPTH),
        .STOCK_W     (STOCK_W)
    ) u_stock (
        .clock    (clock),
        .reset    (reset),
        .dec      (drop_nxt),
        .reload   (do_reload),
        .stock    (stock),
        .sold_out (sold_out)
    );

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl with default parameters.
module tb_vend_credit_ctrl;

    typedef struct packed {
        logic       drop;
        logic       change;
        logic       rej;
        logic [3:0] credit;
        logic [1:0] stock;
        logic       sold;
    } resp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       refund = 1'b0;
    logic       restock = 1'b0;
    logic       drop, change, coin_reject, sold_out;
    logic [3:0] credit;
    logic [1:0] stock;

    resp_t exp_q[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    step_no = 0;

    vend_credit_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .coin        (coin),
        .refund      (refund),
        .restock     (restock),
        .drop        (drop),
        .change      (change),
        .coin_reject (coin_reject),
        .sold_out    (sold_out),
        .credit      (credit),
        .stock       (stock)
    );

    always #5 clock = ~clock;

    function automatic resp_t actual();
        return {drop, change, coin_reject, credit, stock, sold_out};
    endfunction

    task automatic check(input string name, input resp_t act, input resp_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got drop=%0b change=%0b rej=%0b credit=%0d stock=%0d sold_out=%0b, expected drop=%0b change=%0b rej=%0b credit=%0d stock=%0d sold_out=%0b",
                      name, act.drop, act.change, act.rej, act.credit, act.stock, act.sold,
                      exp.drop, exp.change, exp.rej, exp.credit, exp.stock, exp.sold);
    endtask

    // drive one cycle of inputs and queue the response expected after that edge
    task automatic step(input logic [1:0] c, input logic rf, input logic rs,
                        input logic d, input logic ch, input logic rj,
                        input int cr, input int st, input logic so);
        resp_t e;
        coin    = c;
        refund  = rf;
        restock = rs;
        @(posedge clock);
        #1;
        e.drop = d; e.change = ch; e.rej = rj;
        e.credit = 4'(cr); e.stock = 2'(st); e.sold = so;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        resp_t e;
        int    idx = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                idx++;
                check($sformatf("step%0d", idx), actual(), e);
            end
        end
    end

    initial begin : driver
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_state", actual(), {1'b0, 1'b0, 1'b0, 4'd0, 2'd3, 1'b0});

        //    coin  rf  rs  drop chg rej cr st so
        step(2'b01, 0, 0,   0, 0, 0,  1, 3, 0);
        step(2'b10, 0, 0,   1, 0, 0,  0, 2, 0);
        // restock, then 10 and 11 give cand 8: two drops
        step(2'b00, 0, 1,   0, 0, 0,  0, 3, 0);
        step(2'b10, 0, 0,   0, 0, 0,  3, 3, 0);
        step(2'b11, 0, 0,   1, 0, 0,  4, 2, 0);
        step(2'b00, 0, 0,   1, 0, 0,  0, 1, 0);
        // refund of credit 3 with a coin during REFUND
        step(2'b10, 0, 0,   0, 0, 0,  3, 1, 0);
        step(2'b00, 1, 0,   0, 0, 0,  3, 1, 0);
        step(2'b01, 0, 0,   0, 1, 1,  2, 1, 0);
        step(2'b00, 0, 0,   0, 1, 0,  1, 1, 0);
        step(2'b00, 0, 0,   0, 1, 0,  0, 1, 0);
        step(2'b01, 0, 0,   0, 0, 0,  1, 1, 0);
        // restock + coin: credited, no drop; drop follows
        step(2'b10, 0, 1,   0, 0, 0,  4, 3, 0);
        step(2'b00, 0, 0,   1, 0, 0,  0, 2, 0);
        step(2'b11, 0, 0,   1, 0, 0,  1, 1, 0);
        step(2'b10, 0, 0,   1, 0, 0,  0, 0, 1);
        // coins while sold out, then restock and residual drops
        step(2'b11, 0, 0,   0, 0, 0,  5, 0, 1);
        step(2'b11, 0, 0,   0, 0, 0, 10, 0, 1);
        step(2'b00, 0, 1,   0, 0, 0, 10, 3, 0);
        step(2'b00, 0, 0,   1, 0, 0,  6, 2, 0);
        step(2'b00, 0, 0,   1, 0, 0,  2, 1, 0);
        step(2'b00, 0, 0,   0, 0, 0,  2, 1, 0);
        // sell out, then saturate credit at 15
        step(2'b01, 0, 0,   0, 0, 0,  3, 1, 0);
        step(2'b01, 0, 0,   1, 0, 0,  0, 0, 1);
        step(2'b11, 0, 0,   0, 0, 0,  5, 0, 1);
        step(2'b11, 0, 0,   0, 0, 0, 10, 0, 1);
        step(2'b11, 0, 0,   0, 0, 0, 15, 0, 1);
        step(2'b01, 0, 0,   0, 0, 1, 15, 0, 1);
        // overflowing coin with stock: rejected, drop on held credit
        step(2'b00, 0, 1,   0, 0, 0, 15, 3, 0);
        step(2'b11, 0, 0,   1, 0, 1, 11, 2, 0);
        step(2'b00, 0, 0,   1, 0, 0,  7, 1, 0);
        step(2'b00, 0, 0,   1, 0, 0,  3, 0, 1);
        // refund + coin: refund wins, coin rejected
        step(2'b10, 1, 0,   0, 0, 1,  3, 0, 1);
        step(2'b00, 1, 0,   0, 1, 0,  2, 0, 1);

        // asynchronous reset mid-refund, away from any clock edge
        #5;
        reset  = 1'b1;
        refund = 1'b0;
        #1;
        check("async_reset", actual(), {1'b0, 1'b0, 1'b0, 4'd0, 2'd3, 1'b0});
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        step(2'b00, 0, 0,   0, 0, 0,  0, 3, 0);
        // refund with no credit and no coin is a no-op
        step(2'b00, 1, 0,   0, 0, 0,  0, 3, 0);
        step(2'b01, 0, 0,   0, 0, 0,  1, 3, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
